// File: rtl/button_pkg.sv
`default_nettype none
// ============================================================================
// Package    : button_pkg
// Description: Shared types and helpers for the button gesture logic.
// Revision   : 1.0 - initial release
// ============================================================================
package button_pkg;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        PRESSED     = 3'd1,
        LONG_HELD   = 3'd2,
        WAIT_SECOND = 3'd3,
        SECOND_HELD = 3'd4
    } press_state_t;

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ms_timer.sv
`default_nettype none
// ============================================================================
// Module     : ms_timer
// Description: Millisecond prescaler plus saturating ms counter, sync clear.
// Revision   : 1.0 - initial release
// ============================================================================
module ms_timer #(
    parameter int CLK_TICKS_PER_MS = 50_000,
    parameter int CNT_MAX          = 1000,
    parameter int CNT_W            = $clog2(CNT_MAX + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             clear,
    output logic             ms_tick,
    output logic [CNT_W-1:0] ms_cnt
);

    localparam int PRESC_W = $clog2(CLK_TICKS_PER_MS);

    logic [PRESC_W-1:0] presc_q, presc_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    assign ms_tick = (presc_q == PRESC_W'(CLK_TICKS_PER_MS - 1));
    assign ms_cnt  = cnt_q;

    always_comb begin
        presc_d = presc_q;
        cnt_d   = cnt_q;
        if (clear) begin
            presc_d = '0;
            cnt_d   = '0;
        end else if (ms_tick) begin
            presc_d = '0;
            // Saturate so a long hold never wraps back into a threshold match
            if (cnt_q != CNT_W'(CNT_MAX))
                cnt_d = cnt_q + CNT_W'(1);
        end else begin
            presc_d = presc_q + PRESC_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            presc_q <= '0;
            cnt_q   <= '0;
        end else begin
            presc_q <= presc_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule
`default_nettype wire

// File: rtl/press_classifier.sv
`default_nettype none
// ============================================================================
// Module     : press_classifier
// Description: Classifies debounced presses as short, long or double click.
// Revision   : 1.0 - initial release
// ============================================================================
module press_classifier
    import button_pkg::*;
#(
    parameter int CLK_TICKS_PER_MS = 50_000,
    parameter int LONG_MS          = 1000,
    parameter int DOUBLE_MS        = 300
) (
    input  logic clk,
    input  logic reset,
    input  logic db,
    output logic press_tick,
    output logic short_pulse,
    output logic long_pulse,
    output logic double_pulse,
    output logic busy
);

    localparam int MS_MAX = max_int(LONG_MS, DOUBLE_MS);
    localparam int CNT_W  = $clog2(MS_MAX + 1);

    press_state_t     state_q, state_d;
    logic             db_q;
    logic             press_tick_q, press_tick_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             double_q, double_d;
    logic             busy_q, busy_d;
    logic             rise, fall;
    logic             ms_tick;
    logic [CNT_W-1:0] ms_cnt;
    logic             timer_clear;

    assign rise = db & ~db_q;
    assign fall = ~db & db_q;

    // Restarting the timer on every transition makes each state time itself
    assign timer_clear = (state_d != state_q);

    ms_timer #(
        .CLK_TICKS_PER_MS(CLK_TICKS_PER_MS),
        .CNT_MAX         (MS_MAX),
        .CNT_W           (CNT_W)
    ) u_ms_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (timer_clear),
        .ms_tick(ms_tick),
        .ms_cnt (ms_cnt)
    );

    always_comb begin
        state_d      = state_q;
        short_d      = 1'b0;
        long_d       = 1'b0;
        double_d     = 1'b0;
        press_tick_d = rise;
        case (state_q)
            IDLE: begin
                if (rise) state_d = PRESSED;
            end
            PRESSED: begin
                if (ms_tick && (ms_cnt == CNT_W'(LONG_MS - 1))) begin
                    state_d = LONG_HELD;
                    long_d  = 1'b1;
                end else if (fall) begin
                    state_d = WAIT_SECOND;
                end
            end
            LONG_HELD: begin
                if (fall) state_d = IDLE;
            end
            WAIT_SECOND: begin
                if (rise) begin
                    state_d  = SECOND_HELD;
                    double_d = 1'b1;
                end else if (ms_tick && (ms_cnt == CNT_W'(DOUBLE_MS - 1))) begin
                    state_d = IDLE;
                    short_d = 1'b1;
                end
            end
            SECOND_HELD: begin
                if (fall) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            db_q         <= 1'b1;
            press_tick_q <= 1'b0;
            short_q      <= 1'b0;
            long_q       <= 1'b0;
            double_q     <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            db_q         <= db;
            press_tick_q <= press_tick_d;
            short_q      <= short_d;
            long_q       <= long_d;
            double_q     <= double_d;
            busy_q       <= busy_d;
        end
    end

    assign press_tick   = press_tick_q;
    assign short_pulse  = short_q;
    assign long_pulse   = long_q;
    assign double_pulse = double_q;
    assign busy         = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_press_classifier.sv
`default_nettype none
// ============================================================================
// Module     : tb_press_classifier
// Description: Directed self-checking bench for press_classifier (4/5/3 setup).
// Revision   : 1.0 - initial release
// ============================================================================
module tb_press_classifier;
    import button_pkg::*;

    logic clk = 1'b0;
    logic reset;
    logic db;
    logic press_tick, short_pulse, long_pulse, double_pulse, busy;

    int cyc = 0;
    int n_tests = 0;
    int n_fail = 0;
    int n_press, n_short, n_long, n_double, n_busy, n_overlap;
    int t_press, t_short, t_long, t_double;
    int t0;

    press_classifier #(
        .CLK_TICKS_PER_MS(4),
        .LONG_MS         (5),
        .DOUBLE_MS       (3)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .db          (db),
        .press_tick  (press_tick),
        .short_pulse (short_pulse),
        .long_pulse  (long_pulse),
        .double_pulse(double_pulse),
        .busy        (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Pulse monitor samples on the falling edge; cyc names the current cycle
    always @(negedge clk) begin
        if (press_tick)   begin n_press++;  t_press  = cyc; end
        if (short_pulse)  begin n_short++;  t_short  = cyc; end
        if (long_pulse)   begin n_long++;   t_long   = cyc; end
        if (double_pulse) begin n_double++; t_double = cyc; end
        if (busy) n_busy++;
        if ((32'(short_pulse) + 32'(long_pulse) + 32'(double_pulse)) > 1) n_overlap++;
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_counts();
        n_press = 0; n_short = 0; n_long = 0; n_double = 0; n_busy = 0;
        t_press = -1; t_short = -1; t_long = -1; t_double = -1;
    endtask

    task automatic test_reset();
        db = 1'b1; reset = 1'b1;
        step(3);
        n_tests++;
        if ({press_tick, short_pulse, long_pulse, double_pulse, busy} !== 5'b0) begin
            n_fail++; $display("FAIL reset_outputs: got %b expected 00000",
                {press_tick, short_pulse, long_pulse, double_pulse, busy});
        end
        reset = 1'b0;
        clear_counts();
        step(40);
        n_tests++;
        if (n_press !== 0) begin n_fail++; $display("FAIL held_at_reset_press: got %0d expected 0", n_press); end
        n_tests++;
        if ((n_short + n_long + n_double) !== 0) begin
            n_fail++; $display("FAIL held_at_reset_pulses: got %0d expected 0", n_short + n_long + n_double);
        end
        n_tests++;
        if (n_busy !== 0) begin n_fail++; $display("FAIL held_at_reset_busy: got %0d expected 0", n_busy); end
        db = 1'b0;
        step(4);
    endtask

    task automatic test_short();
        clear_counts();
        t0 = cyc; db = 1'b1;
        step(8);
        db = 1'b0;
        step(25);
        n_tests++;
        if (t_press !== t0 + 1 || n_press !== 1) begin
            n_fail++; $display("FAIL short_press_tick: got t=%0d n=%0d expected t=%0d n=1", t_press, n_press, t0 + 1);
        end
        n_tests++;
        if (t_short !== t0 + 21 || n_short !== 1) begin
            n_fail++; $display("FAIL short_pulse_time: got t=%0d n=%0d expected t=%0d n=1", t_short, n_short, t0 + 21);
        end
        n_tests++;
        if (n_long !== 0 || n_double !== 0) begin
            n_fail++; $display("FAIL short_other_pulses: got long=%0d double=%0d expected 0", n_long, n_double);
        end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL short_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_long();
        clear_counts();
        t0 = cyc; db = 1'b1;
        step(30);
        n_tests++;
        if (t_long !== t0 + 21 || n_long !== 1) begin
            n_fail++; $display("FAIL long_pulse_time: got t=%0d n=%0d expected t=%0d n=1", t_long, n_long, t0 + 21);
        end
        n_tests++;
        if (busy !== 1'b1) begin n_fail++; $display("FAIL long_busy_held: got %b expected 1", busy); end
        db = 1'b0;
        step(1);
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL long_busy_drop: got %b expected 0", busy); end
        step(20);
        n_tests++;
        if (n_short !== 0 || n_double !== 0 || n_long !== 1) begin
            n_fail++; $display("FAIL long_after_release: got short=%0d double=%0d long=%0d expected 0/0/1",
                n_short, n_double, n_long);
        end
    endtask

    task automatic test_double();
        clear_counts();
        t0 = cyc; db = 1'b1;
        step(6); db = 1'b0;
        step(5); db = 1'b1;
        step(6); db = 1'b0;
        step(20);
        n_tests++;
        if (n_press !== 2) begin n_fail++; $display("FAIL double_press_ticks: got %0d expected 2", n_press); end
        n_tests++;
        if (t_double !== t0 + 12 || n_double !== 1) begin
            n_fail++; $display("FAIL double_pulse_time: got t=%0d n=%0d expected t=%0d n=1", t_double, n_double, t0 + 12);
        end
        n_tests++;
        if (n_short !== 0 || n_long !== 0) begin
            n_fail++; $display("FAIL double_other_pulses: got short=%0d long=%0d expected 0", n_short, n_long);
        end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL double_busy_end: got %b expected 0", busy); end
    endtask

    task automatic test_rise_at_timeout();
        clear_counts();
        t0 = cyc; db = 1'b1;
        step(2); db = 1'b0;      // WAIT_SECOND starts at t0+3, timeout cycle is t0+14
        step(12); db = 1'b1;
        step(1);
        n_tests++;
        if ({double_pulse, short_pulse} !== 2'b10) begin
            n_fail++; $display("FAIL rise_vs_timeout: got double,short=%b expected 10", {double_pulse, short_pulse});
        end
        step(3); db = 1'b0;
        step(20);
        n_tests++;
        if (n_short !== 0 || n_double !== 1) begin
            n_fail++; $display("FAIL rise_vs_timeout_counts: got short=%0d double=%0d expected 0/1", n_short, n_double);
        end
    endtask

    task automatic test_fall_at_threshold();
        clear_counts();
        t0 = cyc; db = 1'b1;
        step(20); db = 1'b0;     // threshold cycle is t0+20
        step(1);
        n_tests++;
        if ({long_pulse, short_pulse} !== 2'b10) begin
            n_fail++; $display("FAIL fall_vs_threshold: got long,short=%b expected 10", {long_pulse, short_pulse});
        end
        step(20);
        n_tests++;
        if (busy !== 1'b1 || n_short !== 0) begin
            n_fail++; $display("FAIL fall_vs_threshold_hold: got busy=%b short=%0d expected 1/0", busy, n_short);
        end
        db = 1'b1; step(3);
        db = 1'b0; step(2);
        n_tests++;
        if (busy !== 1'b0 || n_long !== 1 || n_short !== 0 || n_double !== 0) begin
            n_fail++; $display("FAIL long_held_exit: got busy=%b long=%0d short=%0d double=%0d expected 0/1/0/0",
                busy, n_long, n_short, n_double);
        end
    endtask

    task automatic test_reset_mid();
        step(3);
        clear_counts();
        t0 = cyc; db = 1'b1;
        step(13);                // ms_cnt is 3 in this cycle
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        n_tests++;
        if ({press_tick, short_pulse, long_pulse, double_pulse, busy} !== 5'b0) begin
            n_fail++; $display("FAIL mid_reset_outputs: got %b expected 00000",
                {press_tick, short_pulse, long_pulse, double_pulse, busy});
        end
        n_tests++;
        if (dut.state_q !== IDLE) begin
            n_fail++; $display("FAIL mid_reset_state: got %0d expected %0d", dut.state_q, IDLE);
        end
        step(40);
        n_tests++;
        if (n_long !== 0 || n_short !== 0 || n_double !== 0 || n_press !== 1) begin
            n_fail++; $display("FAIL mid_reset_after: got long=%0d short=%0d double=%0d press=%0d expected 0/0/0/1",
                n_long, n_short, n_double, n_press);
        end
        n_tests++;
        if (busy !== 1'b0) begin n_fail++; $display("FAIL mid_reset_busy: got %b expected 0", busy); end
        db = 1'b0;
        step(2);
    endtask

    initial begin
        n_overlap = 0;
        clear_counts();
        test_reset();
        test_short();
        test_long();
        test_double();
        test_rise_at_timeout();
        test_fall_at_threshold();
        test_reset_mid();
        n_tests++;
        if (n_overlap !== 0) begin n_fail++; $display("FAIL pulse_exclusive: got %0d overlaps expected 0", n_overlap); end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/press_classifier.md
Name: press_classifier

Overview:
- Sits directly downstream of the switch debouncer and consumes its debounced level `db`.
- Classifies each button gesture as short press, long press or double click, using millisecond timing derived from the system clock.
- Emits one single-cycle pulse per gesture for the FSM/control logic further downstream.
- Assumes `db` is glitch-free and synchronous to `clk`.

Parameters:
- CLK_TICKS_PER_MS, 50_000, clk cycles per 1 ms (50 MHz board clock); must be ≥2.
- LONG_MS, 1000, hold time in ms that qualifies a long press; must be ≥1.
- DOUBLE_MS, 300, max release-to-second-press gap in ms for a double click; must be ≥1.

Ports:
- clk  input  1  system clock; all logic on its rising edge.
- reset  input  1  synchronous, active-high; clears all state on the next rising clk edge.
- db  input  1  debounced switch level (1 = pressed).
- press_tick  output  1  one-cycle pulse on every rising edge of db.
- short_pulse  output  1  one-cycle pulse: a short press was completed.
- long_pulse  output  1  one-cycle pulse: the long-press threshold was reached.
- double_pulse  output  1  one-cycle pulse: a double click was detected.
- busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset values:
  - All outputs 0; state IDLE; prescaler and ms counter 0.
  - db_q (registered db) is reset to 1, so a button already held at reset is not treated as a press.
  - Reset asserted mid-gesture aborts it silently, with no pulse.
- Edge detect: rise = db & ~db_q; fall = ~db & db_q. press_tick is registered, so it is high the cycle after db is first sampled high.
- Timer:
  - The prescaler counts 0..CLK_TICKS_PER_MS-1 and asserts ms_tick when at max, then wraps.
  - ms_cnt increments on ms_tick.
  - Both clear synchronously on every state transition, so each state measures time exactly from its entry.
  - ms_cnt width is $clog2(max(LONG_MS,DOUBLE_MS)+1) and saturates at max; it never wraps.
- FSM states and transitions:
  - IDLE: rise → PRESSED.
  - PRESSED:
    - ms_tick with ms_cnt == LONG_MS-1 → LONG_HELD (long_pulse).
    - Otherwise, fall → WAIT_SECOND.
    - The threshold takes priority over a simultaneous fall.
  - LONG_HELD: fall → IDLE; no further pulses.
  - WAIT_SECOND:
    - rise → SECOND_HELD (double_pulse).
    - Otherwise, ms_tick with ms_cnt == DOUBLE_MS-1 → IDLE (short_pulse).
    - A rise takes priority over a simultaneous timeout.
  - SECOND_HELD: fall → IDLE. A second press never produces long_pulse.
- Pulse outputs:
  - All are registered and high for exactly the first cycle in the destination state (Moore on entry).
  - At most one of short/long/double is high in any cycle.
- Timing:
  - long_pulse is high exactly LONG_MS*CLK_TICKS_PER_MS cycles after the first cycle in PRESSED.
  - short_pulse is high DOUBLE_MS*CLK_TICKS_PER_MS cycles after the first cycle in WAIT_SECOND.
  - A short press therefore reports with latency DOUBLE_MS, by design, so it can be distinguished from a double click.
- press_tick fires on every rise, including the second press of a double click.
- Undefined state encodings return to IDLE.

Decomposition:
- Shared package `button_pkg`: the typedef enum press_state_t {IDLE, PRESSED, LONG_HELD, WAIT_SECOND, SECOND_HELD}.
- Sub-module `ms_timer` (parameter CLK_TICKS_PER_MS; ports clk, reset, clear, ms_tick, ms_cnt) holds the prescaler and saturating counter with synchronous clear.
- The existing free-running tick counter is not reused, because it has no synchronous clear.
- The FSM, edge detect and output registers stay in press_classifier.

Test Plan (CLK_TICKS_PER_MS=4, LONG_MS=5, DOUBLE_MS=3 unless noted):
- Reset with db=1 held, then release reset and keep db=1 for 40 cycles → no press_tick and no pulses; busy=0 throughout.
- db low→high at cycle 10, low at cycle 18, idle after → press_tick at 11; short_pulse exactly once, 12 cycles after the first WAIT_SECOND cycle; long_pulse and double_pulse never asserted.
- db high for 30 cycles → long_pulse exactly once, 20 cycles after entering PRESSED; release → busy drops the cycle after the fall is seen; no short_pulse.
- Press 6 cycles, release 5 cycles, press again 6 cycles → press_tick twice; double_pulse once, the cycle after the second rise is sampled; no short_pulse.
- Second rise on the same cycle as the WAIT_SECOND timeout → double_pulse, not short_pulse. Fall on the same cycle as the long threshold → long_pulse.
- Assert reset for 1 cycle mid-PRESSED (ms_cnt=3) → all outputs 0 next cycle; state IDLE; no pulse later even if db stays high.
